// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared defaults and types for the systolic array datapath
package systolic_pkg;

    localparam int BITS_C_DEF = 16;
    localparam int DIM_DEF    = 8;
    localparam int ROW_W      = $clog2(DIM_DEF);

    typedef logic signed [BITS_C_DEF-1:0] c_row_t [DIM_DEF];

endpackage

// File: rtl/mem_c_collect_lane_delay.sv
// rtl/mem_c_collect_lane_delay.sv - per-lane fixed-delay shift register for deskew
module c_lane_delay
    import systolic_pkg::*;
#(
    parameter int BITS  = BITS_C_DEF,
    parameter int DELAY = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic signed [BITS-1:0] din,
    output logic signed [BITS-1:0] dout
);

    generate
        if (DELAY == 0) begin : g_pass
            // Last lane is already aligned with the wavefront; clock and reset are not needed here.
            logic unused_ctl;
            assign unused_ctl = clk ^ rst_n;
            assign dout = din;
        end else begin : g_sr
            logic signed [BITS-1:0] sr [DELAY];

            // Free-running shift register; cleared on reset so no stale data survives.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int k = 0; k < DELAY; k++) sr[k] <= '0;
                end else begin
                    sr[0] <= din;
                    for (int k = 1; k < DELAY; k++) sr[k] <= sr[k-1];
                end
            end

            assign dout = sr[DELAY-1];
        end
    endgenerate

endmodule

// File: rtl/mem_c_collect.sv
// rtl/mem_c_collect.sv - deskews the skewed C wavefront and buffers aligned rows for readback
module mem_c_collect
    import systolic_pkg::*;
#(
    parameter int BITS_C = BITS_C_DEF,
    parameter int DIM    = DIM_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      in_valid,
    input  logic signed [BITS_C-1:0]  Cin [DIM],
    input  logic                      rd_en,
    input  logic [$clog2(DIM)-1:0]    Crow,
    output logic signed [BITS_C-1:0]  Cout [DIM],
    output logic                      rd_valid,
    output logic                      full,
    output logic                      ovf
);

    localparam int CROW_W = $clog2(DIM);

    logic                     [DIM-2:0]    vpipe;
    logic                                  aligned_v;
    logic signed [BITS_C-1:0]              aligned [DIM];
    logic        [CROW_W-1:0]              wr_row;
    logic                                  cap_we;
    logic signed [BITS_C-1:0]              row_buf [DIM][DIM];

    // Lane i lags lane 0 by i cycles, so it needs DIM-1-i cycles of delay to line up.
    genvar gi;
    generate
        for (gi = 0; gi < DIM; gi++) begin : g_lane
            c_lane_delay #(
                .BITS  (BITS_C),
                .DELAY (DIM - 1 - gi)
            ) u_delay (
                .clk   (clk),
                .rst_n (rst_n),
                .din   (Cin[gi]),
                .dout  (aligned[gi])
            );
        end
    endgenerate

    assign aligned_v = vpipe[DIM-2];
    // clr beats a same-cycle capture; reset also suppresses it.
    assign cap_we    = aligned_v && !full && !clr && rst_n;

    // Valid pipe tracks lane 0 through the same DIM-1 cycles the data needs to align.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            vpipe <= '0;
        end else begin
            vpipe[0] <= in_valid;
            for (int k = 1; k < DIM - 1; k++) vpipe[k] <= vpipe[k-1];
        end
    end

    // Row counter and status flags; overflow is sticky until clr or reset.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wr_row <= '0;
            full   <= 1'b0;
            ovf    <= 1'b0;
        end else if (aligned_v) begin
            if (!full) begin
                wr_row <= wr_row + 1'b1;
                if (wr_row == CROW_W'(DIM - 1)) full <= 1'b1;
            end else begin
                ovf <= 1'b1;
            end
        end
    end

    // Row buffer has no reset; contents are only meaningful once written.
    always_ff @(posedge clk) begin
        if (cap_we) begin
            for (int l = 0; l < DIM; l++) row_buf[wr_row][l] <= aligned[l];
        end
    end

    // Registered read port; non-blocking update gives old data on a same-edge write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            for (int l = 0; l < DIM; l++) Cout[l] <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                for (int l = 0; l < DIM; l++) Cout[l] <= row_buf[Crow][l];
            end
        end
    end

endmodule
